// File: rtl/hulohot_alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hulohot_alu_pkg : shared widths, opcodes, FSM states and response entry type
// Rev 1.0
// ----------------------------------------------------------------------------
package hulohot_alu_pkg;

  localparam int unsigned OPND_W = 3;
  localparam int unsigned RES_W  = 4;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned RSP_W  = OP_W + RES_W;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [RES_W-1:0] z;
  } rsp_t;

endpackage
`default_nettype wire

// File: rtl/hulohot_alu_issuer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hulohot_alu_issuer_if : command and response valid/ready channels
// Rev 1.0
// ----------------------------------------------------------------------------
interface hulohot_alu_issuer_if;
  import hulohot_alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OPND_W-1:0] cmd_a;
  logic [OPND_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_z;
  logic [OP_W-1:0]   rsp_op;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_z, rsp_op
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_z, rsp_op
  );

endinterface
`default_nettype wire

// File: rtl/hulohot_alu_rsp_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hulohot_alu_rsp_fifo : synchronous response FIFO, power-of-two DEPTH
// Rev 1.0
// ----------------------------------------------------------------------------
module hulohot_alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         din,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]  count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (count_q == c_depth);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hulohot_alu_issuer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hulohot_alu_issuer : registers commands onto the ALU, queues tagged results
// Rev 1.0
// ----------------------------------------------------------------------------
module hulohot_alu_issuer
  import hulohot_alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  hulohot_alu_issuer_if.slave         bus,
  output logic      [OPND_W-1:0]      alu_a,
  output logic      [OPND_W-1:0]      alu_b,
  output logic      [OP_W-1:0]        alu_opcode,
  input  wire logic [RES_W-1:0]       alu_z,
  output logic                        busy,
  output logic      [$clog2(DEPTH):0] rsp_count
);

  state_t            state_q, state_d;
  logic [OPND_W-1:0] alu_a_q, alu_a_d;
  logic [OPND_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              busy_q, busy_d;

  logic              w_cmd_ready;
  logic              w_push;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  rsp_t              w_push_ent;
  rsp_t              w_head;

  // Ready depends only on registered state, never on cmd_valid or rsp_ready.
  assign w_cmd_ready = (state_q == ST_IDLE) && !w_fifo_full;
  assign w_push      = (state_q == ST_EXEC);

  assign w_push_ent.op = alu_op_q;
  assign w_push_ent.z  = alu_z;

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && w_cmd_ready) begin
          alu_a_d  = bus.cmd_a;
          alu_b_d  = bus.cmd_b;
          alu_op_d = bus.cmd_op;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_ADD;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      busy_q   <= busy_d;
    end
  end

  hulohot_alu_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_push_ent),
    .pop   (bus.rsp_ready),
    .dout  (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (rsp_count)
  );

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = !w_fifo_empty;
  assign bus.rsp_z     = w_head.z;
  assign bus.rsp_op    = w_head.op;

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hulohot_alu_issuer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hulohot_alu_issuer : directed + random stimulus against a queue-based model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hulohot_alu_issuer;
  import hulohot_alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] alu_a, alu_b;
  logic [1:0] alu_opcode;
  logic [3:0] alu_z;
  logic       busy;
  logic [$clog2(DEPTH):0] rsp_count;

  hulohot_alu_issuer_if bus ();

  hulohot_alu_issuer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_z      (alu_z),
    .busy       (busy),
    .rsp_count  (rsp_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_ref(input logic [2:0] a, input logic [2:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  assign alu_z = alu_ref(alu_a, alu_b, alu_opcode);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: FIFO contents as a queue of {op, z}, plus one in-flight command.
  logic [5:0] q[$];
  bit         m_busy = 0;
  logic [5:0] m_infl;
  logic [2:0] m_a = 0, m_b = 0;
  logic [1:0] m_op = 0;
  int         cyc = 0;
  int         last_acc = 0;

  task automatic model_reset();
    q.delete();
    m_busy = 0;
    m_a = 0; m_b = 0; m_op = 0;
  endtask

  // Called at a falling edge with inputs already set; compares, advances one clock.
  task automatic cycle();
    bit e_ready, acc, pop;
    e_ready = !m_busy && (q.size() < DEPTH);
    check("cmd_ready", bus.cmd_ready, e_ready);
    check("busy", busy, m_busy);
    check("rsp_valid", bus.rsp_valid, q.size() != 0);
    check("rsp_count", rsp_count, q.size());
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_opcode", alu_opcode, m_op);
    if (q.size() != 0) begin
      check("rsp_z", bus.rsp_z, q[0][3:0]);
      check("rsp_op", bus.rsp_op, q[0][5:4]);
    end
    acc = bus.cmd_valid && e_ready;
    pop = bus.rsp_ready && (q.size() != 0);
    @(posedge clk);
    cyc++;
    if (pop) void'(q.pop_front());
    if (m_busy) begin
      q.push_back(m_infl);
      m_busy = 0;
    end else if (acc) begin
      m_a = bus.cmd_a; m_b = bus.cmd_b; m_op = bus.cmd_op;
      m_infl = {bus.cmd_op, alu_ref(bus.cmd_a, bus.cmd_b, bus.cmd_op)};
      m_busy = 1;
      last_acc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
    bit done = 0;
    bus.cmd_valid = 1; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op;
    for (int i = 0; i < 20 && !done; i++) begin
      done = !m_busy && (q.size() < DEPTH);
      cycle();
    end
    bus.cmd_valid = 0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic expect_head(input string tag, input logic [3:0] z, input logic [1:0] op);
    check({tag, "_valid"}, bus.rsp_valid, 1);
    check({tag, "_z"}, bus.rsp_z, z);
    check({tag, "_op"}, bus.rsp_op, op);
  endtask

  task automatic pop_one();
    bus.rsp_ready = 1;
    cycle();
    bus.rsp_ready = 0;
  endtask

  initial begin
    int c1;
    bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_op = 0; bus.rsp_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_count", rsp_count, 0);
    check("rst_busy", busy, 0);
    check("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    rst_n = 1;

    // Single ADD: response visible after the second edge.
    send(3'd3, 3'd5, OP_ADD);
    check("add_rsp_not_yet", bus.rsp_valid, 0);
    cycle();
    expect_head("add35", 4'h8, OP_ADD);
    pop_one();

    // SUB wrap and zero.
    send(3'd1, 3'd2, OP_SUB); cycle();
    expect_head("sub12", 4'hF, OP_SUB);
    pop_one();
    send(3'd7, 3'd7, OP_SUB); cycle();
    expect_head("sub77", 4'h0, OP_SUB);
    pop_one();

    // Back-to-back with valid held high.
    send(3'd6, 3'd3, OP_AND);
    c1 = last_acc;
    check("b2b_busy", busy, 1);
    send(3'd4, 3'd1, OP_OR);
    check("b2b_gap", last_acc - c1, 2);
    cycle();
    expect_head("b2b_and", 4'h2, OP_AND);
    pop_one();
    expect_head("b2b_or", 4'h5, OP_OR);
    pop_one();

    // Backpressure: fill, hold a fifth command, release with one pop.
    for (int i = 0; i < DEPTH; i++) send(3'(i), 3'd1, OP_ADD);
    cycle();
    check("bp_count", rsp_count, 4);
    check("bp_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 1; bus.cmd_a = 3'd5; bus.cmd_b = 3'd6; bus.cmd_op = OP_OR;
    repeat (3) cycle();
    pop_one();
    check("bp_ready_after_pop", bus.cmd_ready, 1);
    cycle();
    bus.cmd_valid = 0;
    check("bp_accepted", busy, 1);
    // Push and pop together at count 3.
    bus.rsp_ready = 1;
    cycle();
    check("pp_count", rsp_count, 3);
    repeat (4) cycle();
    bus.rsp_ready = 0;
    check("drained", rsp_count, 0);

    // Asynchronous reset in the middle of EXEC.
    send(3'd7, 3'd7, OP_ADD);
    check("pre_rst_busy", busy, 1);
    #3 rst_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cmd_ready", bus.cmd_ready, 1);
    check("arst_rsp_valid", bus.rsp_valid, 0);
    check("arst_count", rsp_count, 0);
    check("arst_alu", {alu_a, alu_b, alu_opcode}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (3) cycle();
    send(3'd2, 3'd2, OP_ADD); cycle();
    expect_head("post_rst_add", 4'h4, OP_ADD);
    pop_one();

    // Random traffic: light then heavy backpressure.
    for (int i = 0; i < 600; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_a     = 3'($urandom_range(0, 7));
      bus.cmd_b     = 3'($urandom_range(0, 7));
      bus.cmd_op    = 2'($urandom_range(0, 3));
      bus.rsp_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle();
    end
    bus.cmd_valid = 0;
    bus.rsp_ready = 1;
    repeat (8) cycle();
    check("final_empty", rsp_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
